// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver for the LSB-first serial link.
// Assembles a start-delimited frame into a WIDTH-bit word, with optional even-parity check.
module sipo_rx #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             busy,
    output logic             parity_err,
    output logic             frame_err,
    output logic             state_dbg
);

    localparam int N  = WIDTH + (PARITY_EN ? 1 : 0);
    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic             par, par_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic             valid_nxt, perr_nxt, ferr_nxt;
    logic             last;

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A start always (re)opens a frame, so only the last sample without start returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (!start && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // valid is a bare one-cycle strobe with no ready: the consumer must take dout
    // in the cycle valid is high; dout then holds until the next valid.
    always_comb begin
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        par_nxt   = par;
        dout_nxt  = dout;
        valid_nxt = 1'b0;
        perr_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
        if (start) begin
            ferr_nxt = (state == SHIFT);
            cnt_nxt  = CW'(1);
            par_nxt  = din;
            sr_nxt   = {din, sr[WIDTH-1:1]};
        end else if (state == SHIFT) begin
            cnt_nxt = cnt + 1'b1;
            par_nxt = par ^ din;
            if (cnt < CW'(WIDTH)) sr_nxt = {din, sr[WIDTH-1:1]};
            if (last) begin
                cnt_nxt   = '0;
                valid_nxt = 1'b1;
                // With parity the final sample is the parity bit, so the word is already in sr.
                dout_nxt  = PARITY_EN ? sr : {din, sr[WIDTH-1:1]};
                perr_nxt  = PARITY_EN ? (par ^ din) : 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            sr         <= '0;
            par        <= 1'b0;
            dout       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            sr         <= sr_nxt;
            par        <= par_nxt;
            dout       <= dout_nxt;
            valid      <= valid_nxt;
            parity_err <= perr_nxt;
            frame_err  <= ferr_nxt;
        end
    end

    assign busy      = (state == SHIFT);
    assign state_dbg = state;

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: one instance without parity, one with, both checked every cycle
// against a bit-list frame model.
module tb_sipo_rx;

  logic clk = 1'b0;
  logic rst;
  logic start0, din0, start1, din1;
  logic [3:0] dout0, dout1;
  logic valid0, busy0, perr0, ferr0, st0;
  logic valid1, busy1, perr1, ferr1, st1;

  int total = 0;
  int bad = 0;

  logic [3:0] exp_q[$];
  logic [3:0] exp_qp[$];

  int         m_n[2];
  logic [7:0] m_bits[2];
  logic       e_valid[2];
  logic [3:0] e_dout[2];
  logic       e_pe[2];
  logic       e_fe[2];

  always #5 clk = ~clk;

  sipo_rx #(.WIDTH(4), .PARITY_EN(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .din(din0), .dout(dout0), .valid(valid0),
    .busy(busy0), .parity_err(perr0), .frame_err(ferr0), .state_dbg(st0)
  );

  sipo_rx #(.WIDTH(4), .PARITY_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .din(din1), .dout(dout1), .valid(valid1),
    .busy(busy1), .parity_err(perr1), .frame_err(ferr1), .state_dbg(st1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame model: collected samples as a bit list; a full list of N samples is a delivered word.
  task automatic model(input int k, input logic s, input logic d, input logic r);
    int nn;
    logic [3:0] w;
    nn = 4 + k;
    e_valid[k] = 1'b0;
    e_pe[k] = 1'b0;
    e_fe[k] = 1'b0;
    if (r) begin
      m_n[k] = 0;
      m_bits[k] = '0;
      e_dout[k] = '0;
    end else if (s) begin
      if (m_n[k] > 0) e_fe[k] = 1'b1;
      m_bits[k] = '0;
      m_bits[k][0] = d;
      m_n[k] = 1;
    end else if (m_n[k] > 0) begin
      m_bits[k][m_n[k]] = d;
      m_n[k]++;
      if (m_n[k] == nn) begin
        w = m_bits[k][3:0];
        e_valid[k] = 1'b1;
        e_dout[k] = w;
        e_pe[k] = (k == 1) ? ^m_bits[k][4:0] : 1'b0;
        if (k == 0) exp_q.push_back(w);
        else exp_qp.push_back(w);
        m_n[k] = 0;
      end
    end
  endtask

  task automatic step(input logic s0, input logic d0, input logic s1, input logic d1, input logic r);
    rst = r;
    start0 = s0;
    din0 = d0;
    start1 = s1;
    din1 = d1;
    @(posedge clk);
    model(0, s0, d0, r);
    model(1, s1, d1, r);
    #1;
    check("valid0", valid0, e_valid[0]);
    check("dout0", dout0, e_dout[0]);
    check("busy0", busy0, m_n[0] > 0);
    check("perr0", perr0, e_pe[0]);
    check("ferr0", ferr0, e_fe[0]);
    check("valid1", valid1, e_valid[1]);
    check("dout1", dout1, e_dout[1]);
    check("busy1", busy1, m_n[1] > 0);
    check("perr1", perr1, e_pe[1]);
    check("ferr1", ferr1, e_fe[1]);
    if (e_valid[0]) check("sb0", dout0, exp_q.pop_front());
    if (e_valid[1]) check("sb1", dout1, exp_qp.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame0(input logic [3:0] w);
    for (int i = 0; i < 4; i++) step(i == 0, w[i], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame1(input logic [3:0] w, input logic p);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, i == 0, (i < 4) ? w[i] : p, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0;
      m_bits[k] = '0;
      e_valid[k] = 1'b0;
      e_dout[k] = '0;
      e_pe[k] = 1'b0;
      e_fe[k] = 1'b0;
    end

    // reset held with start and din high
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(3);

    // basic frame 4'hB
    frame0(4'hB);
    check("basic_valid", valid0, 1'b1);
    check("basic_dout", dout0, 4'hB);
    idle(3);
    check("basic_hold", dout0, 4'hB);

    // back-to-back frames
    frame0(4'hB);
    frame0(4'h6);
    check("b2b_dout", dout0, 4'h6);
    check("b2b_ferr", ferr0, 1'b0);
    idle(2);

    // parity good, then parity bad
    frame1(4'hB, 1'b1);
    check("par_ok_perr", perr1, 1'b0);
    check("par_ok_dout", dout1, 4'hB);
    idle(2);
    frame1(4'hB, 1'b0);
    check("par_bad_perr", perr1, 1'b1);
    check("par_bad_valid", valid1, 1'b1);
    idle(2);

    // abort mid-frame, then frame 4'hC
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_ferr", ferr0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("abort_dout", dout0, 4'hC);
    idle(2);

    // abort on the last-sample cycle
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("abort_last_ferr", ferr0, 1'b1);
    check("abort_last_valid", valid0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_last_dout", dout0, 4'h5);
    idle(2);

    // reset mid-frame, then clean frame 4'h5
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("rst_mid_dout", dout0, 4'h0);
    idle(2);
    frame0(4'h5);
    check("post_rst_dout", dout0, 4'h5);
    idle(2);

    // random traffic on both instances
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 6) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 149) == 0);
    end
    idle(6);
    check("q0_drained", exp_q.size(), 0);
    check("q1_drained", exp_qp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in parallel-out receiver: the deserializing end of the team's LSB-first serial link, sitting opposite the parallel-in serial-out shifter. It captures a framed bit stream, delimited by a one-cycle `start` pulse, into a `WIDTH`-bit word. When the word is complete it presents the word with a one-cycle `valid` strobe. It optionally checks an even-parity bit and flags aborted frames.

## Interface
- `WIDTH`, default 4: data bits per frame; legal range 2..32.
- `PARITY_EN`, default 0: 1 means one even-parity bit follows the data bits; 0 means no parity bit.
- `clk`  input  1  rising-edge clock; all state changes on this edge.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  frame delimiter; high in the same cycle as data bit 0 on `din`.
- `din`  input  1  serial data, LSB first, then the parity bit if `PARITY_EN`=1.
- `dout`  output  `WIDTH`  last completed word; held until the next `valid`.
- `valid`  output  1  one-cycle pulse; `dout` is new in this cycle.
- `busy`  output  1  high while a frame is partially received.
- `parity_err`  output  1  one-cycle pulse alongside `valid` when parity fails; always 0 if `PARITY_EN`=0.
- `frame_err`  output  1  one-cycle pulse when a frame is aborted by a new `start`.

## Operation
- N = `WIDTH` + `PARITY_EN` samples per frame.
- Bit counter `cnt` is wide enough to hold N.
- Data shift register `sr[WIDTH-1:0]` shifts right, with the new bit entering at the MSB: `sr <= {din, sr[WIDTH-1:1]}`. After `WIDTH` data samples, bit 0 is in `sr[0]`.
- Running parity accumulator `par` is the XOR of every sample in the frame, including the parity bit.
- States:
  - IDLE: `din` is ignored unless `start`=1.
    - On `start`: shift `din` in, set `par`=`din`, set `cnt`=1, go to SHIFT.
  - SHIFT: on every cycle, sample `din` and increment `cnt`.
    - Data samples (`cnt` < `WIDTH`) shift into `sr`. The parity sample is not shifted into `sr`; it only updates `par`.
    - On the sample taken with `cnt`=N-1 (the last one): go to IDLE, load `dout` with the final word, and assert `valid` on the next cycle.
    - If `PARITY_EN`=1, `parity_err` = final `par` (1 means odd total, which is an error).
- `start` in SHIFT, including on the last-sample cycle:
  - Abort the current frame: no `valid` and no `dout` update.
  - Pulse `frame_err`.
  - Treat `din` as bit 0 of a new frame: `cnt`=1, `par`=`din`, and stay in SHIFT.
- `start` in IDLE in the same cycle that `valid` is high is a legal back-to-back frame, with no error.
- A parity error does not suppress delivery: `dout` is updated and `valid` pulses together with `parity_err`.
- `busy` = (state == SHIFT), registered.

## Timing
- Start pulse in cycle 0 (`din` = bit 0). Samples are taken in cycles 0..N-1.
- `valid`, new `dout` and `parity_err` are visible in cycle N; latency is N cycles from `start`.
- `busy` is high in cycles 1..N-1 and low in cycle N unless a new `start` arrived in cycle N-1.
- `frame_err` is visible in the cycle after the aborting `start`.
- Throughput: one frame every N cycles, with no idle gap required.
- Reset:
  - `rst` sampled high forces IDLE and clears `cnt`, `sr`, `par`, `dout`, `valid`, `busy`, `parity_err` and `frame_err`, all to 0, on that edge.
  - `rst` dominates `start`.
  - A partially received frame is discarded silently, with no `frame_err`.
  - First possible `start` is the cycle after `rst` deasserts.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use `WIDTH`=4.
- **Reset:** hold `rst` for 2 cycles with `start`=1 and `din`=1 → all outputs 0, `busy`=0, no `valid` after release.
- **Basic frame (`PARITY_EN`=0):** `start` in cycle 0, `din` = 1,1,0,1 in cycles 0..3 → in cycle 4, `valid`=1 and `dout`=4'hB; `busy` high in cycles 1-3; `dout` holds 4'hB afterwards.
- **Back-to-back frames:** frame 4'hB, then `start` in cycle 4 with `din` = 0,1,1,0 → `valid` in cycles 4 and 8; `dout`=4'hB then 4'h6; `frame_err` never asserted.
- **Parity (`PARITY_EN`=1):**
  - Data 1,1,0,1 with parity bit 1 → `valid` in cycle 5, `dout`=4'hB, `parity_err`=0.
  - Same data with parity bit 0 → `valid` and `parity_err` both pulse; `dout`=4'hB.
- **Abort:**
  - `start` with bits 1,0, then `start` again in cycle 2 with `din` = 0,0,1,1 → `frame_err` pulses in cycle 3; the single `valid` is in cycle 6 with `dout`=4'hC.
  - `start` on the last-sample cycle also aborts that frame.
- **Reset mid-frame:** `rst` in cycle 2 of a frame → no `valid`, no `frame_err`; `dout` = 0; a following clean frame 4'h5 is delivered correctly.
